// File: rtl/vip_axi3_tracker_pkg.sv
// Shared constants and types for the AXI3 write-path tracking blocks.
// The defaults match the AXI3 example bench: 2-bit IDs, 4 outstanding writes
// per ID and 8 outstanding writes in total.
package vip_axi3_tracker_pkg;

  localparam int AXI3_ID_WIDTH   = 2;
  localparam int AXI3_MAX_PER_ID = 4;
  localparam int AXI3_MAX_TOTAL  = 8;

  typedef logic [AXI3_ID_WIDTH-1:0] axi3_id_t;

endpackage

// File: rtl/axi3_id_counter.sv
// Saturating up/down counter that tracks outstanding writes for one AWID.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   inc_i      one AW accepted for this ID
//   dec_i      one B retired for this ID
//   at_max_o   count == MAX (no further AW may be accepted for this ID)
//   is_zero_o  count == 0 (a B for this ID would be unexpected)
module axi3_id_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic at_max_o,
  output logic is_zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o  = (cnt_q == W'(MAX));
  assign is_zero_o = (cnt_q == '0);

  // inc and dec together cancel out.  Saturation at both ends is defensive:
  // the gate upstream and the unexpected-B classification keep it from
  // ever being exercised.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !at_max_o)
      cnt_d = cnt_q + W'(1);
    else if (dec_i && !inc_i && !is_zero_o)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axi3_wr_outstanding_limiter.sv
// AXI3 write-path governor on the AW and B channels.  Counts outstanding
// writes per AWID and globally, stalls AW when either limit is reached, and
// retires writes on B handshakes.  A B with no outstanding write for its ID
// raises a sticky error that remembers the first offending BID.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m_awvalid/m_awid/m_awready  master-side AW handshake (ready is gated)
//   s_awvalid/s_awready         slave-side AW handshake (valid is gated)
//   s_bvalid/s_bid/m_bready     B handshake, observed only
//   outstanding_total, busy     global count and count != 0
//   b_unexp_err/b_unexp_id      sticky unexpected-B flag and captured BID
//   err_clr                     clears the flag and captured ID
module axi3_wr_outstanding_limiter
  import vip_axi3_tracker_pkg::*;
#(
  parameter int ID_WIDTH   = AXI3_ID_WIDTH,
  parameter int MAX_PER_ID = AXI3_MAX_PER_ID,
  parameter int MAX_TOTAL  = AXI3_MAX_TOTAL,
  parameter int CNT_W      = $clog2(MAX_PER_ID + 1),
  parameter int TOT_W      = $clog2(MAX_TOTAL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_awvalid,
  input  logic [ID_WIDTH-1:0] m_awid,
  output logic                m_awready,
  output logic                s_awvalid,
  input  logic                s_awready,
  input  logic                s_bvalid,
  input  logic [ID_WIDTH-1:0] s_bid,
  input  logic                m_bready,
  output logic [TOT_W-1:0]    outstanding_total,
  output logic                busy,
  output logic                b_unexp_err,
  output logic [ID_WIDTH-1:0] b_unexp_id,
  input  logic                err_clr
);

  localparam int NUM_ID = 2 ** ID_WIDTH;

  logic [NUM_ID-1:0]   at_max, is_zero, inc, dec;
  logic [TOT_W-1:0]    total_q, total_d;
  logic                err_q, err_d;
  logic [ID_WIDTH-1:0] eid_q, eid_d;
  logic                aw_allow, aw_acc, b_hs, b_ret, b_unexp;

  // Gate from registered counts only: never looks at s_awready, and a B
  // retiring this cycle does not open the gate until the next one.
  assign aw_allow  = !at_max[m_awid] && (total_q < TOT_W'(MAX_TOTAL));
  assign s_awvalid = m_awvalid & aw_allow;
  assign m_awready = s_awready & aw_allow;

  assign aw_acc  = s_awvalid & s_awready;
  assign b_hs    = s_bvalid & m_bready;
  assign b_ret   = b_hs & !is_zero[s_bid];
  assign b_unexp = b_hs &  is_zero[s_bid];

  for (genvar g = 0; g < NUM_ID; g++) begin : g_id
    assign inc[g] = aw_acc && (m_awid == ID_WIDTH'(g));
    assign dec[g] = b_ret  && (s_bid  == ID_WIDTH'(g));

    axi3_id_counter #(.MAX(MAX_PER_ID), .W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (inc[g]),
      .dec_i     (dec[g]),
      .at_max_o  (at_max[g]),
      .is_zero_o (is_zero[g])
    );
  end

  always_comb begin
    total_d = total_q;
    case ({aw_acc, b_ret})
      2'b10:   total_d = total_q + TOT_W'(1);
      2'b01:   total_d = total_q - TOT_W'(1);
      default: total_d = total_q;
    endcase
  end

  // A new unexpected B beats err_clr: the flag stays set and the new BID is
  // captured, so the cleared-then-reoffended case is not lost.
  always_comb begin
    err_d = err_q;
    eid_d = eid_q;
    if (b_unexp) begin
      if (!err_q || err_clr) begin
        err_d = 1'b1;
        eid_d = s_bid;
      end
    end else if (err_clr) begin
      err_d = 1'b0;
      eid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
      err_q   <= 1'b0;
      eid_q   <= '0;
    end else begin
      total_q <= total_d;
      err_q   <= err_d;
      eid_q   <= eid_d;
    end
  end

  assign outstanding_total = total_q;
  assign busy              = (total_q != '0);
  assign b_unexp_err       = err_q;
  assign b_unexp_id        = eid_q;

endmodule

// File: tb/tb_axi3_wr_outstanding_limiter.sv
module tb_axi3_wr_outstanding_limiter;
  import vip_axi3_tracker_pkg::*;

  localparam int IDW  = AXI3_ID_WIDTH;
  localparam int MPI  = AXI3_MAX_PER_ID;
  localparam int MTOT = AXI3_MAX_TOTAL;
  localparam int TW   = $clog2(MTOT + 1);
  localparam int NID  = 2 ** IDW;

  logic           clk, rst;
  logic           m_awvalid, m_awready, s_awvalid, s_awready;
  logic [IDW-1:0] m_awid, s_bid, b_unexp_id;
  logic           s_bvalid, m_bready, busy, b_unexp_err, err_clr;
  logic [TW-1:0]  outstanding_total;

  axi3_wr_outstanding_limiter dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awready(m_awready),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .m_bready(m_bready),
    .outstanding_total(outstanding_total), .busy(busy),
    .b_unexp_err(b_unexp_err), .b_unexp_id(b_unexp_id), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;

  // Reference model: outstanding writes held as plain per-ID integer counts.
  int       m_cnt[NID];
  int       m_tot;
  bit       m_err;
  axi3_id_t m_eid;

  task automatic model_reset();
    for (int i = 0; i < NID; i++) m_cnt[i] = 0;
    m_tot = 0; m_err = 0; m_eid = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    bit allow;
    allow = (m_cnt[m_awid] < MPI) && (m_tot < MTOT);
    chk({tag, ".s_awvalid"}, 32'(s_awvalid), 32'(m_awvalid & allow));
    chk({tag, ".m_awready"}, 32'(m_awready), 32'(s_awready & allow));
    chk({tag, ".total"},     32'(outstanding_total), 32'(m_tot));
    chk({tag, ".busy"},      32'(busy), 32'(m_tot != 0));
    chk({tag, ".err"},       32'(b_unexp_err), 32'(m_err));
    chk({tag, ".eid"},       32'(b_unexp_id), 32'(m_eid));
  endtask

  // One clock: drive at negedge, check outputs, then advance model at posedge.
  task automatic cyc(input string tag, input bit awv, input int awid, input bit awr,
                     input bit bv, input int bid, input bit br, input bit clr);
    bit allow, acc, bh, ret, unexp;
    @(negedge clk);
    m_awvalid = awv; m_awid = IDW'(awid); s_awready = awr;
    s_bvalid = bv; s_bid = IDW'(bid); m_bready = br; err_clr = clr;
    #1;
    chk_outputs(tag);
    allow = (m_cnt[awid] < MPI) && (m_tot < MTOT);
    acc   = awv && awr && allow;
    bh    = bv && br;
    ret   = bh && (m_cnt[bid] != 0);
    unexp = bh && (m_cnt[bid] == 0);
    @(posedge clk);
    if (acc) begin m_cnt[awid]++; m_tot++; end
    if (ret) begin m_cnt[bid]--;  m_tot--; end
    if (unexp) begin
      if (!m_err || clr) begin m_err = 1; m_eid = axi3_id_t'(bid); end
    end else if (clr) begin
      m_err = 0; m_eid = '0;
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    m_awvalid = 0; m_awid = '0; s_awready = 0;
    s_bvalid = 0; s_bid = '0; m_bready = 0; err_clr = 0;
    model_reset();
    #12;
    chk_outputs("reset");
    // With counts at zero the gate is open during reset.
    m_awvalid = 1; s_awready = 1; #1;
    chk("reset_gate_sv", 32'(s_awvalid), 32'd1);
    chk("reset_gate_mr", 32'(m_awready), 32'd1);
    m_awvalid = 0; s_awready = 0;
    @(negedge clk); rst = 1'b0;

    // Single AW id1, its B three cycles later.
    cyc("aw1", 1, 1, 1, 0, 0, 0, 0);
    idle("aw1_wait"); idle("aw1_wait");
    cyc("b1", 0, 0, 0, 1, 1, 1, 0);
    idle("b1_done");

    // Five AWs on id2: the fifth stalls until a B id2 retires.
    for (int i = 0; i < 4; i++) cyc("aw2", 1, 2, 1, 0, 0, 0, 0);
    cyc("aw2_stall", 1, 2, 1, 0, 0, 0, 0);
    cyc("aw2_stall", 1, 2, 1, 0, 0, 0, 0);
    cyc("aw2_bsame", 1, 2, 1, 1, 2, 1, 0);
    cyc("aw2_pass", 1, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("b2_drain", 0, 0, 0, 1, 2, 1, 0);
    idle("b2_done");

    // Two AWs on each ID reach the global limit.
    for (int i = 0; i < 8; i++) cyc("aw_all", 1, i / 2, 1, 0, 0, 0, 0);
    cyc("aw_glob_stall", 1, 0, 1, 0, 0, 0, 0);
    cyc("aw_glob_stall", 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc("b_all", 0, 0, 0, 1, i / 2, 1, 0);
    // cnt[3] = 1: accept and retire on id3 in the same cycle.
    cyc("same_id3", 1, 3, 1, 1, 3, 1, 0);
    cyc("same_id3_after", 1, 3, 0, 0, 0, 0, 0);
    cyc("b3", 0, 0, 0, 1, 3, 1, 0);
    idle("b3_done");

    // Unexpected B handling.
    cyc("bad_b2", 0, 0, 0, 1, 2, 1, 0);
    cyc("bad_b1", 0, 0, 0, 1, 1, 1, 0);
    cyc("clr_bad_b0", 0, 0, 0, 1, 0, 1, 1);
    cyc("clr", 0, 0, 0, 0, 0, 0, 1);
    idle("clr_done");

    // Asynchronous reset mid-cycle with three outstanding.
    for (int i = 0; i < 3; i++) cyc("aw_pre_rst", 1, i, 1, 0, 0, 0, 0);
    @(negedge clk);
    m_awvalid = 0; s_awready = 0; s_bvalid = 0; m_bready = 0; err_clr = 0;
    #2 rst = 1'b1;
    model_reset();
    #1 chk_outputs("async_rst");
    #1 rst = 1'b0;
    cyc("late_b0", 0, 0, 0, 1, 0, 1, 0);
    idle("late_b0_done");
    cyc("clr2", 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int awid, bid;
      awid = $urandom_range(NID - 1);
      bid  = $urandom_range(NID - 1);
      cyc("rand", $urandom_range(99) < 70, awid, $urandom_range(99) < 75,
          $urandom_range(99) < 45, bid, $urandom_range(99) < 80,
          $urandom_range(99) < 5);
    end
    idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/axi3_wr_outstanding_limiter.md
# axi3_wr_outstanding_limiter

Parametrised AXI3 write-path governor placed between the bench's AXI3 master BFM port and the DUT slave port, on the AW and B channels only. It tracks outstanding write transactions per AWID, stalls AW when a per-ID or global limit is reached, and retires transactions on B handshakes. It flags any B response with no matching outstanding write. Its width and limit parameters default to the values the AXI3 example bench uses today, and its depth limits generalise them.

## Interface
- ID_WIDTH, 2: AWID/BID width; tracks 2**ID_WIDTH IDs.
- MAX_PER_ID, 4: maximum outstanding writes per ID; must be ≥1.
- MAX_TOTAL, 8: maximum outstanding writes across all IDs; must satisfy MAX_PER_ID ≤ MAX_TOTAL.
- CNT_W, $clog2(MAX_PER_ID+1): per-ID counter width (derived).
- TOT_W, $clog2(MAX_TOTAL+1): total counter width (derived).

Clock and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- m_awvalid  in  1  master AW valid
- m_awid  in  ID_WIDTH  master AW ID
- m_awready  out  1  = s_awready & aw_allow
- s_awvalid  out  1  = m_awvalid & aw_allow
- s_awready  in  1  slave AW ready
- s_bvalid  in  1  slave B valid
- s_bid  in  ID_WIDTH  slave B ID
- m_bready  in  1  master B ready (B passes straight through; only observed here)
- outstanding_total  out  TOT_W  current global count
- busy  out  1  outstanding_total != 0
- b_unexp_err  out  1  sticky unexpected-B flag
- b_unexp_id  out  ID_WIDTH  BID of the first unexpected B since the last clear
- err_clr  in  1  clears b_unexp_err and b_unexp_id

## Operation
- aw_allow = (cnt[m_awid] < MAX_PER_ID) && (total < MAX_TOTAL). It is combinational from registered counters only. A B retiring in the same cycle does not relax the limit.
- AW accept = s_awvalid & s_awready; it increments cnt[m_awid] and total.
- B retire = s_bvalid & m_bready & (cnt[s_bid] != 0); it decrements cnt[s_bid] and total.
- Unexpected B = s_bvalid & m_bready & (cnt[s_bid] == 0).
  - No counter changes.
  - If b_unexp_err is 0: set it and capture s_bid.
  - If b_unexp_err is already 1: keep the original captured ID.
- Accept and retire in the same cycle, same ID: cnt unchanged and total unchanged.
- Accept and retire in the same cycle, different IDs: each per-ID counter moves ±1, and total is unchanged.
- err_clr and a new unexpected B in the same cycle: the error wins. The flag stays 1, and b_unexp_id takes the new s_bid.
- Counters never wrap. An increment at the limit is impossible because of gating. A decrement at 0 is classified as an unexpected B.
- No AXI value checks: AWLEN, BRESP and data channels are outside this block.

## Timing
- Reset values: all cnt = 0, total = 0, b_unexp_err = 0, b_unexp_id = 0.
  - Hence busy = 0, outstanding_total = 0 and aw_allow = 1, so s_awvalid/m_awready follow their inputs immediately.
- Reset mid-operation clears all counters asynchronously. Transactions in flight are forgotten, and their later B responses flag as unexpected.
- Counter and flag updates are visible on the cycle after the handshake edge, so latency is 1 cycle.
- The gate is zero-latency combinational: a limit reached at edge N stalls AW from cycle N+1.
- AXI rule kept: s_awvalid depends on m_awvalid and registered state only, never on s_awready. No combinational loop is created.

## Structure
- Shared package vip_axi3_tracker_pkg holds:
  - the default constants AXI3_ID_WIDTH = 2, AXI3_MAX_PER_ID = 4, AXI3_MAX_TOTAL = 8;
  - typedef axi3_id_t.
- Sub-module axi3_id_counter holds one saturating up/down counter with inc, dec, at_max and is_zero outputs. It is generated 2**ID_WIDTH times.
- The top level holds the total counter, the gate logic and the error capture.

## Test plan
- Reset, then a single AW with ID 1 followed 3 cycles later by its B with ID 1 -> cnt[1] goes 0→1→0, busy high for exactly those cycles, no error.
- Five back-to-back AWs with ID 2 and no B -> four accepted. The fifth sees m_awready = 0 and s_awvalid = 0 until one B with ID 2 is accepted, then it passes the next cycle.
- Two AWs on each of IDs 0–3 (8 total) -> a ninth AW with ID 0 stalls on the global limit, with outstanding_total = 8.
- With cnt[3] = 1, an AW accept with ID 3 and a B with ID 3 in the same cycle -> cnt[3] stays 1, total unchanged, and aw_allow unchanged.
- B with ID 2 when cnt[2] = 0 -> b_unexp_err = 1 and b_unexp_id = 2. A second bad B with ID 1 keeps the ID at 2. err_clr together with a bad B with ID 0 -> flag stays 1 and the ID becomes 0.
- rst pulsed asynchronously mid-cycle with 3 outstanding -> all outputs return to reset values before the next edge. The late B then sets b_unexp_err.
